// File: rtl/load_use_hazard_unit_if.sv
// Decode-stage hazard inputs, memory handshake and stall/flush/status outputs
// shared between the pipeline and the load-use hazard unit.
interface load_use_hazard_unit_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       rsD;
    logic [4:0]       rtD;
    logic             useRsD;
    logic             useRtD;
    logic             memWriteD;
    logic             memToRegD;
    logic             regWriteD;
    logic [4:0]       writeRegD;
    logic             memReadyM;

    logic             stallF;
    logic             stallD;
    logic             stallE;
    logic             stallM;
    logic             flushE;
    logic [1:0]       hazardState;
    logic [CNT_W-1:0] stallCount;
    logic             memTimeout;

    modport master (
        output rsD, rtD, useRsD, useRtD, memWriteD, memToRegD, regWriteD,
               writeRegD, memReadyM,
        input  stallF, stallD, stallE, stallM, flushE, hazardState,
               stallCount, memTimeout
    );

    modport slave (
        input  rsD, rtD, useRsD, useRtD, memWriteD, memToRegD, regWriteD,
               writeRegD, memReadyM,
        output stallF, stallD, stallE, stallM, flushE, hazardState,
               stallCount, memTimeout
    );
endinterface

// File: rtl/load_use_hazard_unit.sv
// Load-use stall/bubble and data-memory wait freeze for the 5-stage MIPS pipeline,
// with shadow EX/MEM slots, hazard FSM, stall statistics and a sticky wait timeout.
module load_use_hazard_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    load_use_hazard_unit_if.slave hz
);
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_BUBBLE  = 2'd1,
        ST_MEMWAIT = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                ex_valid_q, ex_load_q, ex_store_q, ex_reg_write_q;
    logic [4:0]          ex_write_reg_q;
    logic                mem_valid_q, mem_access_q;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                timeout_q, timeout_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

    logic load_use_c;
    logic mem_wait_c;
    logic stall_f_c, stall_d_c, stall_e_c, stall_m_c, flush_e_c;

    // Store data (rt of a store) is forwarded in MEM, so only address/ALU reads stall.
    always_comb begin
        load_use_c = ex_valid_q & ex_load_q & ex_reg_write_q & (ex_write_reg_q != 5'd0) &
                     ((hz.useRsD & (hz.rsD == ex_write_reg_q)) |
                      (hz.useRtD & ~hz.memWriteD & (hz.rtD == ex_write_reg_q)));
        mem_wait_c = mem_valid_q & mem_access_q & ~hz.memReadyM;
    end

    // Control outputs and next hazard state; memory wait outranks load-use.
    always_comb begin
        state_d   = ST_RUN;
        stall_f_c = 1'b0;
        stall_d_c = 1'b0;
        stall_e_c = 1'b0;
        stall_m_c = 1'b0;
        flush_e_c = 1'b0;
        if (mem_wait_c) begin
            state_d   = ST_MEMWAIT;
            stall_f_c = 1'b1;
            stall_d_c = 1'b1;
            stall_e_c = 1'b1;
            stall_m_c = 1'b1;
        end else if (load_use_c) begin
            state_d   = ST_BUBBLE;
            stall_f_c = 1'b1;
            stall_d_c = 1'b1;
            flush_e_c = 1'b1;
        end
    end

    // Wait-length counter saturates at the threshold; the flag is sticky.
    always_comb begin
        wait_cnt_d = '0;
        if (mem_wait_c) begin
            if (wait_cnt_q != WAIT_W'(TIMEOUT_CYCLES)) begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end else begin
                wait_cnt_d = wait_cnt_q;
            end
        end
        timeout_d = timeout_q | (mem_wait_c & (wait_cnt_d == WAIT_W'(TIMEOUT_CYCLES)));

        stall_cnt_d = stall_cnt_q;
        if (stall_f_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Shadow EX/MEM slots advance with the pipeline and freeze during a memory wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q     <= 1'b0;
            ex_load_q      <= 1'b0;
            ex_store_q     <= 1'b0;
            ex_reg_write_q <= 1'b0;
            ex_write_reg_q <= 5'd0;
            mem_valid_q    <= 1'b0;
            mem_access_q   <= 1'b0;
        end else if (!mem_wait_c) begin
            mem_valid_q    <= ex_valid_q;
            mem_access_q   <= ex_valid_q & (ex_load_q | ex_store_q);
            ex_valid_q     <= ~load_use_c;
            ex_load_q      <= hz.memToRegD & ~load_use_c;
            ex_store_q     <= hz.memWriteD & ~load_use_c;
            ex_reg_write_q <= hz.regWriteD & ~load_use_c;
            ex_write_reg_q <= load_use_c ? 5'd0 : hz.writeRegD;
        end
    end

    assign hz.stallF      = stall_f_c;
    assign hz.stallD      = stall_d_c;
    assign hz.stallE      = stall_e_c;
    assign hz.stallM      = stall_m_c;
    assign hz.flushE      = flush_e_c;
    assign hz.hazardState = state_q;
    assign hz.stallCount  = stall_cnt_q;
    assign hz.memTimeout  = timeout_q;
endmodule

// File: tb/tb_load_use_hazard_unit.sv
// Directed and random checks of load_use_hazard_unit against an instruction-level
// pipeline model kept in the bench.
module tb_load_use_hazard_unit;
    localparam int TMO = 16;

    logic clk;
    logic rst_n;
    int   checks_total;
    int   checks_passed;

    load_use_hazard_unit_if #(.CNT_W(16)) hif ();

    load_use_hazard_unit #(.TIMEOUT_CYCLES(TMO), .CNT_W(16)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .hz   (hif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: the instruction occupying EX and MEM, plus expected statistics.
    typedef struct {
        bit valid;
        bit is_load;
        bit is_store;
        bit writes;
        int dest;
    } instr_t;

    instr_t m_ex, m_mem;
    int     m_state, m_stalls, m_wait_run;
    bit     m_timeout;
    bit     e_lu, e_mw;

    task automatic model_reset();
        m_ex = '{0, 0, 0, 0, 0};
        m_mem = '{0, 0, 0, 0, 0};
        m_state = 0;
        m_stalls = 0;
        m_wait_run = 0;
        m_timeout = 0;
    endtask

    task automatic model_eval();
        bit rs_hit, rt_hit;
        rs_hit = hif.useRsD && (int'(hif.rsD) == m_ex.dest);
        rt_hit = hif.useRtD && !hif.memWriteD && (int'(hif.rtD) == m_ex.dest);
        e_lu = m_ex.valid && m_ex.is_load && m_ex.writes && (m_ex.dest != 0) && (rs_hit || rt_hit);
        e_mw = m_mem.valid && (m_mem.is_load || m_mem.is_store) && !hif.memReadyM;
    endtask

    task automatic model_clock();
        instr_t dec;
        if (e_mw) begin
            m_wait_run++;
            if (m_wait_run >= TMO) m_timeout = 1;
        end else begin
            m_wait_run = 0;
        end
        if ((e_mw || e_lu) && m_stalls < 65535) m_stalls++;
        m_state = e_mw ? 2 : (e_lu ? 1 : 0);
        if (!e_mw) begin
            dec = '{1, hif.memToRegD, hif.memWriteD, hif.regWriteD, int'(hif.writeRegD)};
            m_mem = m_ex;
            m_ex = e_lu ? '{0, 0, 0, 0, 0} : dec;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        model_eval();
        chk({tag, ".stallF"}, 32'(hif.stallF), 32'(e_mw || e_lu));
        chk({tag, ".stallD"}, 32'(hif.stallD), 32'(e_mw || e_lu));
        chk({tag, ".stallE"}, 32'(hif.stallE), 32'(e_mw));
        chk({tag, ".stallM"}, 32'(hif.stallM), 32'(e_mw));
        chk({tag, ".flushE"}, 32'(hif.flushE), 32'(e_lu && !e_mw));
        chk({tag, ".hazardState"}, 32'(hif.hazardState), 32'(m_state));
        chk({tag, ".stallCount"}, 32'(hif.stallCount), 32'(m_stalls));
        chk({tag, ".memTimeout"}, 32'(hif.memTimeout), 32'(m_timeout));
    endtask

    task automatic drive(input int rs, input int rt, input bit urs, input bit urt,
                         input bit mw, input bit ml, input bit rw, input int wr, input bit rdy);
        hif.rsD = 5'(rs);
        hif.rtD = 5'(rt);
        hif.useRsD = urs;
        hif.useRtD = urt;
        hif.memWriteD = mw;
        hif.memToRegD = ml;
        hif.regWriteD = rw;
        hif.writeRegD = 5'(wr);
        hif.memReadyM = rdy;
    endtask

    // One pipeline cycle: drive just after an edge, check mid-cycle, advance the model.
    task automatic step(input string tag, input int rs, input int rt, input bit urs, input bit urt,
                        input bit mw, input bit ml, input bit rw, input int wr, input bit rdy);
        drive(rs, rt, urs, urt, mw, ml, rw, wr, rdy);
        #2;
        check_all(tag);
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic nop(input string tag, input bit rdy);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 0, rdy);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        checks_total = 0;
        checks_passed = 0;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        model_reset();
        #1;
        check_all("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // lw $21 then add reading $21: exactly one bubble.
        step("lw21", 3, 21, 1, 0, 0, 1, 1, 21, 1);
        step("add_stall", 21, 22, 1, 1, 0, 0, 1, 4, 1);
        step("add_go", 21, 22, 1, 1, 0, 0, 1, 4, 1);
        nop("lu_nop1", 1);
        nop("lu_nop2", 1);
        chk("lu.stallCount", 32'(hif.stallCount), 32'd1);
        chk("lu.state_run", 32'(hif.hazardState), 32'd0);

        // Store data from a load in EX is forwarded later; no stall.
        do_reset("rst_sw");
        step("lw21b", 3, 21, 1, 0, 0, 1, 1, 21, 1);
        step("sw_data", 3, 21, 1, 1, 1, 0, 0, 0, 1);
        nop("sw_nop1", 1);
        nop("sw_nop2", 1);
        chk("sw.stallCount", 32'(hif.stallCount), 32'd0);

        // Register $0 and empty EX slot never stall.
        do_reset("rst_r0");
        step("empty_ex", 21, 0, 1, 0, 0, 0, 1, 5, 1);
        step("lw0", 3, 0, 1, 0, 0, 1, 1, 0, 1);
        step("add_r0", 0, 0, 1, 1, 0, 0, 1, 6, 1);
        nop("r0_nop", 1);
        chk("r0.stallCount", 32'(hif.stallCount), 32'd0);

        // Three-cycle memory wait.
        do_reset("rst_mw3");
        step("lw8", 3, 8, 1, 0, 0, 1, 1, 8, 1);
        nop("mw3_adv", 1);
        for (int i = 0; i < 3; i++) nop("mw3_wait", 0);
        nop("mw3_ready", 1);
        nop("mw3_after", 1);
        chk("mw3.stallCount", 32'(hif.stallCount), 32'd3);
        chk("mw3.memTimeout", 32'(hif.memTimeout), 32'd0);

        // Twenty-cycle wait trips the sticky timeout.
        do_reset("rst_mw20");
        step("lw9", 3, 9, 1, 0, 0, 1, 1, 9, 1);
        nop("mw20_adv", 1);
        for (int i = 0; i < 20; i++) nop("mw20_wait", 0);
        nop("mw20_ready", 1);
        nop("mw20_after", 1);
        chk("mw20.stallCount", 32'(hif.stallCount), 32'd20);
        chk("mw20.memTimeout", 32'(hif.memTimeout), 32'd1);

        // Asynchronous reset in the middle of a wait.
        do_reset("rst_pre");
        step("lw10", 3, 10, 1, 0, 0, 1, 1, 10, 1);
        nop("mwr_adv", 1);
        nop("mwr_wait1", 0);
        nop("mwr_wait2", 0);
        chk("mwr.stallM_before", 32'(hif.stallM), 32'd1);
        do_reset("rst_midwait");
        chk("mwr.stallCount_after", 32'(hif.stallCount), 32'd0);

        // Random traffic with a small register pool to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 3) != 0));
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
